if_stage: RTL

- Instruction-fetch stage of the 5-stage LoongArch pipeline; feeds the decode stage.
- Contains the pre-IF next-PC logic, the PC register and the synchronous inst SRAM request.
- Has a one-entry instruction buffer, so fetched words survive decode back-pressure.
- Applies branch redirects from decode and cancels wrong-path fetches.

---
 rtl/cpu_defs.sv | 11 +
 rtl/if_stage.sv | 97 +++++++++
 2 files changed

// File: rtl/cpu_defs.sv
// Shared CPU-wide constants for the LA32R pipeline stages.
package cpu_defs;

    localparam logic [31:0] RESET_PC       = 32'h1c000000;
    localparam int          PC_W           = 32;
    localparam int          INST_W         = 32;
    localparam logic [31:0] NOP_INST       = 32'h03400000;
    // Packed IF->ID bus layout once stages are bussed together: {adef, pc, inst}
    localparam int          FS_TO_DS_BUS_W = 1 + PC_W + INST_W;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: pre-IF next-PC selection, PC register, inst SRAM
// request, a one-entry instruction buffer and branch redirect/cancel.
module if_stage #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter int          PC_W     = cpu_defs::PC_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ds_allowin,
    input  logic                          br_taken,
    input  logic [PC_W-1:0]               br_target,
    output logic                          fs_to_ds_valid,
    output logic [PC_W-1:0]               fs_pc,
    output logic [cpu_defs::INST_W-1:0]   fs_inst,
    output logic                          fs_adef,
    output logic                          inst_sram_en,
    output logic [3:0]                    inst_sram_we,
    output logic [PC_W-1:0]               inst_sram_addr,
    output logic [31:0]                   inst_sram_wdata,
    input  logic [cpu_defs::INST_W-1:0]   inst_sram_rdata
);

    import cpu_defs::*;

    logic                pf_valid;
    logic                fs_valid;
    logic                buf_valid;
    logic                br_pending;
    logic [PC_W-1:0]     pc_r;
    logic [PC_W-1:0]     br_target_r;
    logic [INST_W-1:0]   inst_buf;
    logic [PC_W-1:0]     nextpc;
    logic                fs_allowin;
    logic                fs_update;

    // A live redirect beats a parked one, which beats sequential fetch.
    always_comb begin
        nextpc = pc_r + 32'd4;
        if (br_taken) begin
            nextpc = br_target;
        end else if (br_pending) begin
            nextpc = br_target_r;
        end
    end

    assign fs_allowin = ~fs_valid | ds_allowin;
    assign fs_update  = pf_valid & fs_allowin;

    assign inst_sram_en    = fs_update & (nextpc[1:0] == 2'b00);
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pf_valid    <= 1'b0;
            fs_valid    <= 1'b0;
            pc_r        <= RESET_PC - 32'd4;
            buf_valid   <= 1'b0;
            br_pending  <= 1'b0;
            br_target_r <= '0;
            inst_buf    <= '0;
        end else begin
            pf_valid <= 1'b1;
            if (fs_update) begin
                pc_r       <= nextpc;
                fs_valid   <= 1'b1;
                buf_valid  <= 1'b0;
                br_pending <= 1'b0;
            end else if (br_taken) begin
                // IF cannot take the target now: kill the wrong-path word and park the redirect.
                br_pending  <= 1'b1;
                br_target_r <= br_target;
                fs_valid    <= 1'b0;
                buf_valid   <= 1'b0;
            end else if (fs_valid & ~buf_valid & ~ds_allowin) begin
                // SRAM data is only valid for one cycle, so hold it across the stall.
                inst_buf  <= inst_sram_rdata;
                buf_valid <= 1'b1;
            end
        end
    end

    assign fs_pc          = pc_r;
    assign fs_adef        = fs_valid & (pc_r[1:0] != 2'b00);
    assign fs_to_ds_valid = fs_valid & ~br_taken;

    always_comb begin
        fs_inst = inst_sram_rdata;
        if (fs_adef) begin
            fs_inst = '0;
        end else if (buf_valid) begin
            fs_inst = inst_buf;
        end
    end

endmodule
